// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

   // StFault is only reachable when FETCH_BOUNDS_EN is defined.
   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StHold,
      StFault
   } fetch_state_e;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INST_BYTES);
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: memory read port, decode handshake/redirect, IF/ID register.
// Fault exists only when FETCH_BOUNDS_EN is defined.
interface instruction_fetch_if;
   import fetch_pkg::*;

   logic [XLEN-1:0] Addr;
   logic [XLEN-1:0] Inst;
   logic            Stall;
   logic            Redirect;
   logic [XLEN-1:0] Target;
   logic [XLEN-1:0] IfId_Inst;
   logic [XLEN-1:0] IfId_PC;
   logic [XLEN-1:0] IfId_PC4;
   logic            IfId_Valid;
`ifdef FETCH_BOUNDS_EN
   logic            Fault;
`endif

   modport master (
      input  Inst, Stall, Redirect, Target,
`ifdef FETCH_BOUNDS_EN
      output Fault,
`endif
      output Addr, IfId_Inst, IfId_PC, IfId_PC4, IfId_Valid
   );

   modport slave (
      output Inst, Stall, Redirect, Target,
`ifdef FETCH_BOUNDS_EN
      input  Fault,
`endif
      input  Addr, IfId_Inst, IfId_PC, IfId_PC4, IfId_Valid
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc, valid} holding register catching the in-flight fetch during a stall.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic            i_drain,
   input  logic [XLEN-1:0] i_inst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_valid,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_pc,
   output logic            o_valid
);

   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_pc;
   logic            r_valid;

   // Clear beats load: a redirect squashes whatever was being captured.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_inst  <= NOP_INST;
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_inst  <= NOP_INST;
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_inst  <= i_inst;
         r_pc    <= i_pc;
         r_valid <= i_valid;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_inst  = r_inst;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, alignment of one-cycle-late Inst with its PC, stall skid, redirect squash.
// Defining FETCH_BOUNDS_EN adds an out-of-range fetch check with a sticky Fault state.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned     MEM_WORDS = 256
) (
   input logic                 Clk,
   input logic                 Rst_n,
   instruction_fetch_if.master if_bus
);

   localparam logic [XLEN-1:0] ResetPc = {RESET_PC[XLEN-1:2], 2'b00};

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_req_valid;
   logic [XLEN-1:0] r_ifid_inst;
   logic [XLEN-1:0] r_ifid_pc;
   logic [XLEN-1:0] r_ifid_pc4;
   logic            r_ifid_valid;

   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_sk_inst;
   logic [XLEN-1:0] w_sk_pc;
   logic            w_sk_valid;
   logic            w_redirect;
   logic            w_advance;
   logic            w_drain;
   logic            w_issue;
   logic            w_sk_load;
   logic            w_sk_clear;

`ifdef FETCH_BOUNDS_EN
   localparam logic [XLEN:0] MemBytes = (XLEN+1)'(MEM_WORDS) * (XLEN+1)'(INST_BYTES);

   logic r_fault;
   logic w_oob;

   assign w_oob        = {1'b0, r_pc} >= MemBytes;
   assign if_bus.Fault = r_fault;
`else
   // Without the bounds check the memory aliases addresses through its own index bits.
   logic w_unused_mem_words;
   assign w_unused_mem_words = ^MEM_WORDS;
`endif

   always_comb begin
      w_target   = if_bus.Target & ~32'h0000_0003;
      w_redirect = if_bus.Redirect && (r_state != StFault);
      w_advance  = !w_redirect &&
                   ((r_state == StBoot) || ((r_state == StRun) && !if_bus.Stall));
      w_drain    = !w_redirect && (r_state == StHold) && !if_bus.Stall;
      w_issue    = w_advance || w_drain;
      w_sk_load  = !w_redirect && (r_state == StRun) && if_bus.Stall;
      w_sk_clear = w_redirect;
   end

   fetch_skid_buf u_skid (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .i_load  (w_sk_load),
      .i_clear (w_sk_clear),
      .i_drain (w_drain),
      .i_inst  (if_bus.Inst),
      .i_pc    (r_req_pc),
      .i_valid (r_req_valid),
      .o_inst  (w_sk_inst),
      .o_pc    (w_sk_pc),
      .o_valid (w_sk_valid)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state      <= StBoot;
         r_pc         <= ResetPc;
         r_req_pc     <= '0;
         r_req_valid  <= 1'b0;
         r_ifid_inst  <= NOP_INST;
         r_ifid_pc    <= '0;
         r_ifid_pc4   <= '0;
         r_ifid_valid <= 1'b0;
`ifdef FETCH_BOUNDS_EN
         r_fault      <= 1'b0;
`endif
      end else if (w_redirect) begin
         // IF/ID payload is left alone; only the valid bit is squashed.
         r_pc         <= w_target;
         r_req_valid  <= 1'b0;
         r_ifid_valid <= 1'b0;
         r_state      <= StBoot;
      end else begin
         if (w_advance) begin
            r_ifid_inst  <= if_bus.Inst;
            r_ifid_pc    <= r_req_pc;
            r_ifid_pc4   <= next_pc(r_req_pc);
            r_ifid_valid <= r_req_valid;
         end else if (w_drain) begin
            r_ifid_inst  <= w_sk_inst;
            r_ifid_pc    <= w_sk_pc;
            r_ifid_pc4   <= next_pc(w_sk_pc);
            r_ifid_valid <= w_sk_valid;
         end

         unique case (r_state)
            StBoot:  r_state <= StRun;
            StRun:   if (if_bus.Stall) r_state <= StHold;
            StHold:  if (!if_bus.Stall) r_state <= StRun;
            StFault: if (!if_bus.Stall) r_ifid_valid <= 1'b0;
         endcase

         // Issue the current PC; the bounds check overrides the state written above.
         if (w_issue) begin
`ifdef FETCH_BOUNDS_EN
            if (w_oob) begin
               r_req_valid <= 1'b0;
               r_fault     <= 1'b1;
               r_state     <= StFault;
            end else
`endif
            begin
               r_req_pc    <= r_pc;
               r_req_valid <= 1'b1;
               r_pc        <= next_pc(r_pc);
            end
         end
      end
   end

   assign if_bus.Addr       = r_pc;
   assign if_bus.IfId_Inst  = r_ifid_inst;
   assign if_bus.IfId_PC    = r_ifid_pc;
   assign if_bus.IfId_PC4   = r_ifid_pc4;
   assign if_bus.IfId_Valid = r_ifid_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table through a scoreboard queue, plus
// an asynchronous-reset-during-stall sequence. FETCH_BOUNDS_EN swaps the wrap vectors for fault ones.
module tb_instruction_fetch;
   import fetch_pkg::*;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] target;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic        fault;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_PC  (32'h0000_0000),
      .MEM_WORDS (256)
   ) dut (
      .Clk    (clk),
      .Rst_n  (rst_n),
      .if_bus (bus)
   );

   // 256-word memory image; words are tagged so Inst can never be confused with a PC.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [7:0] idx;
      idx = a[9:2];
      return 32'hC0DE_0000 ^ {24'h0, idx};
   endfunction

   always_ff @(posedge clk) bus.Inst <= mem_word(bus.Addr);

   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[$];
   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic r, input logic [31:0] t, input logic [31:0] a,
                      input logic v, input logic [31:0] p, input logic f);
      vec_t e;
      e.stall = s; e.redir = r; e.target = t; e.addr = a; e.valid = v; e.pc = p; e.fault = f;
      vecs.push_back(e);
   endtask

   task automatic chk_vec(input vec_t e, input int idx);
      chk($sformatf("v%0d Addr", idx), bus.Addr, e.addr);
      chk($sformatf("v%0d IfId_Valid", idx), 32'(bus.IfId_Valid), 32'(e.valid));
      if (e.valid) begin
         chk($sformatf("v%0d IfId_PC", idx), bus.IfId_PC, e.pc);
         chk($sformatf("v%0d IfId_PC4", idx), bus.IfId_PC4, e.pc + 32'd4);
         chk($sformatf("v%0d IfId_Inst", idx), bus.IfId_Inst, mem_word(e.pc));
      end
`ifdef FETCH_BOUNDS_EN
      chk($sformatf("v%0d Fault", idx), 32'(bus.Fault), 32'(e.fault));
`endif
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " Addr"}, bus.Addr, 32'h0);
      chk({tag, " IfId_Valid"}, 32'(bus.IfId_Valid), 32'h0);
      chk({tag, " IfId_Inst"}, bus.IfId_Inst, 32'h0);
      chk({tag, " IfId_PC"}, bus.IfId_PC, 32'h0);
      chk({tag, " IfId_PC4"}, bus.IfId_PC4, 32'h0);
`ifdef FETCH_BOUNDS_EN
      chk({tag, " Fault"}, 32'(bus.Fault), 32'h0);
`endif
   endtask

   initial begin
      vec_t e;
      int   cnt;

      bus.Stall    = 1'b0;
      bus.Redirect = 1'b0;
      bus.Target   = 32'h0;

      //  stall redir target        Addr after   valid IfId_PC        fault
      add(0, 0, 32'h0,         32'h04,      0, 32'h0,         0);  // BOOT edge
      add(0, 0, 32'h0,         32'h08,      1, 32'h00,        0);
      add(0, 0, 32'h0,         32'h0C,      1, 32'h04,        0);
      add(0, 0, 32'h0,         32'h10,      1, 32'h08,        0);
      add(1, 0, 32'h0,         32'h10,      1, 32'h08,        0);  // 3-cycle stall
      add(1, 0, 32'h0,         32'h10,      1, 32'h08,        0);
      add(1, 0, 32'h0,         32'h10,      1, 32'h08,        0);
      add(0, 0, 32'h0,         32'h14,      1, 32'h0C,        0);  // skid drains
      add(0, 0, 32'h0,         32'h18,      1, 32'h10,        0);
      add(0, 0, 32'h0,         32'h1C,      1, 32'h14,        0);
      add(0, 1, 32'h41,        32'h40,      0, 32'h0,         0);  // redirect
      add(0, 0, 32'h0,         32'h44,      0, 32'h0,         0);
      add(0, 0, 32'h0,         32'h48,      1, 32'h40,        0);
      add(0, 0, 32'h0,         32'h4C,      1, 32'h44,        0);
      add(1, 0, 32'h0,         32'h4C,      1, 32'h44,        0);  // fill skid
      add(1, 1, 32'h80,        32'h80,      0, 32'h0,         0);  // redirect beats stall
      add(0, 0, 32'h0,         32'h84,      0, 32'h0,         0);
      add(0, 0, 32'h0,         32'h88,      1, 32'h80,        0);
      add(0, 0, 32'h0,         32'h8C,      1, 32'h84,        0);
      add(1, 0, 32'h0,         32'h8C,      1, 32'h84,        0);  // 1-cycle stall
      add(0, 0, 32'h0,         32'h90,      1, 32'h88,        0);
      add(0, 0, 32'h0,         32'h94,      1, 32'h8C,        0);
`ifdef FETCH_BOUNDS_EN
      add(0, 1, 32'h3F4,       32'h3F4,     0, 32'h0,         0);
      add(0, 0, 32'h0,         32'h3F8,     0, 32'h0,         0);
      add(0, 0, 32'h0,         32'h3FC,     1, 32'h3F4,       0);
      add(0, 0, 32'h0,         32'h400,     1, 32'h3F8,       0);
      add(0, 0, 32'h0,         32'h400,     1, 32'h3FC,       1);  // fault on issuing 0x400
      add(0, 0, 32'h0,         32'h400,     0, 32'h0,         1);
      add(0, 1, 32'h0,         32'h400,     0, 32'h0,         1);  // redirect ignored
      add(1, 0, 32'h0,         32'h400,     0, 32'h0,         1);
`else
      add(0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 32'h0,       0);  // PC wrap
      add(0, 0, 32'h0,         32'h0,       0, 32'h0,         0);
      add(0, 0, 32'h0,         32'h4,       1, 32'hFFFF_FFFC, 0);
      add(0, 0, 32'h0,         32'h8,       1, 32'h0,         0);
`endif

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         bus.Stall    = vecs[i].stall;
         bus.Redirect = vecs[i].redir;
         bus.Target   = vecs[i].target;
         sb.push_back(vecs[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk_vec(e, i);
      end

      // Reset pulsed mid-stall, between clock edges.
      bus.Redirect = 1'b0;
      bus.Stall    = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async reset");
      @(negedge clk);
      rst_n     = 1'b1;
      bus.Stall = 1'b0;
      cnt = 0;
      while (!bus.IfId_Valid && cnt < 6) begin
         @(negedge clk);
         cnt++;
      end
      chk("restart latency", 32'(cnt), 32'd2);
      chk("restart IfId_PC", bus.IfId_PC, 32'h0);
      chk("restart IfId_Inst", bus.IfId_Inst, mem_word(32'h0));
      @(negedge clk);
      chk("restart next IfId_PC", bus.IfId_PC, 32'h4);
      chk("restart next Addr", bus.Addr, 32'hC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the `InstructionMemory` read port and produces the IF/ID pipeline register. It sits between the hazard/branch logic and the decode stage. It holds the program counter, issues one word address per cycle, and aligns the memory's one-cycle-late `Inst` with the PC that requested it. It also absorbs decode stalls with a one-entry skid buffer and squashes wrong-path fetches on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `MEM_WORDS`, default 256: instruction memory depth in 32-bit words; used only for the bounds check.
- `Clk`  in  1  rising-edge clock shared with `InstructionMemory`.
- `Rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `Addr`  out  32  byte address to `InstructionMemory.Addr`; equals the PC register.
- `Inst`  in  32  memory output; valid for the `Addr` presented in the previous cycle.
- `Stall`  in  1  decode cannot accept; hold IF/ID and PC.
- `Redirect`  in  1  branch/jump taken; load `Target`.
- `Target`  in  32  redirect byte address; bits [1:0] ignored (forced 0).
- `IfId_Inst`  out  32  fetched instruction.
- `IfId_PC`  out  32  address of `IfId_Inst`.
- `IfId_PC4`  out  32  `IfId_PC` + 4, modulo 2^32.
- `IfId_Valid`  out  1  IF/ID holds a real instruction.
- `Fault`  out  1  out-of-range fetch; present only with `FETCH_BOUNDS_EN`.

## Operation
- Internal registers: `PC` (drives `Addr`), `ReqPC` and `ReqValid` (request in flight), a skid entry `{SkInst, SkPC, SkValid}`, and the IF/ID outputs.
- The FSM has four states: BOOT, RUN, HOLD, and FAULT (FAULT exists only with the macro).
- Reset values:
  - `PC` and `Addr` = `RESET_PC`; `ReqValid` = 0; skid empty.
  - All IF/ID outputs = 0 (`IfId_PC4` = 0 too); `Fault` = 0.
  - State = BOOT.
- BOOT: the first edge sets `ReqPC`←`PC`, `ReqValid`←1, `PC`←`PC`+4, and goes to RUN. Its IF/ID update is the normal RUN-advance rule below. With the reset values this sets `IfId_Valid` to 0.
- RUN with `Stall`=0 (advance):
  - IF/ID ← {`Inst`, `ReqPC`, `ReqPC`+4, `ReqValid`}.
  - `ReqPC`←`PC`, `ReqValid`←1, `PC`←`PC`+4.
- RUN with `Stall`=1:
  - IF/ID and `PC` hold.
  - Skid ← {`Inst`, `ReqPC`, `ReqValid`}; go to HOLD.
- HOLD with `Stall`=1: everything holds. `Addr` stays constant, so the memory keeps re-reading `PC`.
- HOLD with `Stall`=0:
  - IF/ID ← skid entry; skid cleared.
  - `ReqPC`←`PC`, `ReqValid`←1, `PC`←`PC`+4; go to RUN.
- `Redirect`=1 takes priority over `Stall` in every state except FAULT:
  - `PC`←{`Target`[31:2],2'b00}.
  - `ReqValid`←0, skid cleared, `IfId_Valid`←0; go to BOOT.
  - `IfId_Inst`, `IfId_PC` and `IfId_PC4` hold.
- Arithmetic is 32-bit unsigned. `PC` wraps 32'hFFFF_FFFC → 0.
- Reset asserted mid-operation (any state): all registers return to reset values immediately (asynchronous).

## Timing
- Addr-to-output latency: the instruction for `Addr`=A in cycle n appears on IF/ID in cycle n+2 (two edges), absent stalls.
- Throughput: one instruction per cycle in RUN.
- After reset release: first `IfId_Valid`=1 (PC=`RESET_PC`) in the second cycle after the first rising edge.
- Redirect penalty: the edge sampling `Redirect` produces one bubble cycle. The next edge produces a second bubble. The third edge presents `Target` on IF/ID with `IfId_Valid`=1.
- Stall release: the skid instruction appears on IF/ID at the release edge. The next sequential instruction follows at the next edge, with no bubble.

## Configuration
- `FETCH_BOUNDS_EN` defined:
  - Adds the `Fault` port and the FAULT state.
  - Trigger: an edge that would set `ReqPC`←`PC` with `PC` ≥ `MEM_WORDS`*4.
  - Response: `ReqValid`←0, `Fault`←1, state FAULT.
  - In FAULT, `PC` and IF/ID freeze. `IfId_Valid` drops to 0 on the next non-stalled edge and stays 0.
  - `Redirect` is ignored; only reset clears FAULT.
- `FETCH_BOUNDS_EN` undefined: no `Fault` port and no check. Addresses beyond memory alias through the memory's own index bits.

## Structure
- Package `fetch_pkg` holds:
  - the FSM state typedef (BOOT, RUN, HOLD, FAULT);
  - `XLEN`=32 and `INST_BYTES`=4;
  - `NOP_INST`=32'h0000_0000.
- Sub-module `fetch_skid_buf` is the one-entry {inst, pc, valid} holding register, with load, clear and drain controls.

## Test plan
- Reset, no stall, memory word k = k: `Addr` steps 0,4,8…; `IfId_Inst` = 0,1,2… with `IfId_PC` = 0,4,8… from the second cycle after reset.
- `Stall`=1 for 3 cycles while IF/ID = PC 0x8: IF/ID holds 0x8 and `Addr` holds 0x10. After release, IF/ID shows 0xC then 0x10, with no gap or duplicate.
- `Redirect`=1 with `Target`=0x41 while streaming: `IfId_Valid`=0 for 2 cycles, then `IfId_PC`=0x40 with `IfId_Inst`=mem[16].
- `Redirect` and `Stall` both 1 in the same cycle: redirect wins; the skid is cleared; the next valid output is at PC `Target`.
- `Rst_n` pulsed low mid-stall: all outputs 0 asynchronously; the sequence restarts at `RESET_PC`.
- With `FETCH_BOUNDS_EN`, `MEM_WORDS`=4, run from 0: `Fault`=1 when `PC`=0x10 is issued. Outputs after that:
  - IF/ID last valid entry is PC 0xC.
  - `IfId_Valid`=0 thereafter; a subsequent `Redirect` has no effect.
